// File: rtl/inst_fetch_ctrl.sv
//==============================================================================
// Module   : inst_fetch_ctrl
// Purpose  : Fetch sequencer: owns the PC, drives the instruction ROM address and
//            registers fetched instructions into a valid/ready IR for decode.
//            Optional macro FETCH_PERF_CNT_EN adds fetch/stall/flush counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module inst_fetch_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'b1110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] inst_addr,
    input  logic [9:0]  inst_data,
    output logic [9:0]  ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic        halted,
    output logic        busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [9:0]  ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;

    logic        capture;
    logic        flush;
    logic        clear_cnt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        capture    = 1'b0;
        flush      = 1'b0;
        clear_cnt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d      = RESET_PC;
                    state_d   = FETCH;
                    clear_cnt = 1'b1;
                end else if (ir_valid_q && ir_ready) begin
                    ir_valid_d = 1'b0;
                end
            end

            FETCH: begin
                // Redirect beats both capture and stall; the target is fetched next cycle.
                if (redirect_valid) begin
                    flush      = ir_valid_q;
                    ir_valid_d = 1'b0;
                    pc_d       = redirect_target;
                end else if (!ir_valid_q || ir_ready) begin
                    capture    = 1'b1;
                    ir_d       = inst_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (inst_data[9:6] == HALT_OPCODE) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end

            HALTED: begin
                if (redirect_valid) begin
                    flush      = ir_valid_q;
                    ir_valid_d = 1'b0;
                    pc_d       = redirect_target;
                    state_d    = FETCH;
                end else if (start) begin
                    ir_valid_d = 1'b0;
                    pc_d       = RESET_PC;
                    state_d    = FETCH;
                    clear_cnt  = 1'b1;
                end else if (ir_valid_q && ir_ready) begin
                    ir_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 10'b0;
            ir_pc_q    <= 16'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign inst_addr = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = (state_q == HALTED);
    assign busy      = (state_q == FETCH);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        stall;

    assign stall = (state_q == FETCH) && ir_valid_q && !ir_ready;

    // Saturating counters; clear only when a start is actually acted upon.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (clear_cnt) begin
            fetch_count_d = 32'd0;
            stall_count_d = 32'd0;
            flush_count_d = 16'd0;
        end else begin
            if (capture && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
            if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_d = stall_count_q + 32'd1;
            end
            if (flush && (flush_count_q != 16'hFFFF)) begin
                flush_count_d = flush_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
            flush_count_q <= 16'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
//==============================================================================
// Module   : tb_inst_fetch_ctrl
// Purpose  : Self-checking bench for inst_fetch_ctrl (directed scenarios plus
//            randomized traffic against a cycle-level reference model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] inst_addr;
    logic [9:0]  inst_data;
    logic [9:0]  ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halted;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [15:0] flush_count;
`endif

    inst_fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .inst_addr       (inst_addr),
        .inst_data       (inst_data),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .busy            (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    logic [9:0] rom [0:65535];
    assign inst_data = rom[inst_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the machine is either idle, running or halted.
    logic [15:0] m_pc;
    logic [15:0] m_ir_pc;
    logic [9:0]  m_ir;
    bit          m_vld;
    bit          m_running;
    bit          m_halted;
    longint      m_fc, m_sc, m_flc;

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = 10'h0; m_ir_pc = 16'h0; m_vld = 0;
        m_running = 0; m_halted = 0;
        m_fc = 0; m_sc = 0; m_flc = 0;
    endtask

    task automatic model_start();
        m_pc = 16'h0000; m_vld = 0; m_running = 1; m_halted = 0;
        m_fc = 0; m_sc = 0; m_flc = 0;
    endtask

    task automatic model_redirect();
        if (m_vld && m_flc < 64'hFFFF) m_flc++;
        m_vld = 0; m_pc = redirect_target; m_running = 1; m_halted = 0;
    endtask

    task automatic model_step();
        if (m_running) begin
            if (m_vld && !ir_ready && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (redirect_valid) begin
                model_redirect();
            end else if (!m_vld || ir_ready) begin
                m_ir = rom[m_pc]; m_ir_pc = m_pc; m_vld = 1;
                if (m_fc < 64'hFFFF_FFFF) m_fc++;
                if (m_ir[9:6] == 4'b1110) begin
                    m_running = 0; m_halted = 1;
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end
        end else if (m_halted) begin
            if (redirect_valid) model_redirect();
            else if (start) model_start();
            else if (ir_ready) m_vld = 0;
        end else begin
            if (start) model_start();
            else if (ir_ready) m_vld = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({inst_addr, ir, ir_pc, ir_valid, halted, busy} !== 45'h0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%h ir=%h ir_pc=%h v=%b h=%b b=%b, want all zero",
                     inst_addr, ir, ir_pc, ir_valid, halted, busy);
        end
        ir_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 16'h0033;
        repeat (3) tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({busy, ir_valid, inst_addr} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL idle_ignores_redirect: got busy=%b v=%b addr=%h, want 0 0 0000",
                     busy, ir_valid, inst_addr);
        end
    endtask

    task automatic test_sequence();
        logic [9:0]  exp_ir [3] = '{10'h118, 10'h05F, 10'h380};
        pulse_start();
        n_checks++;
        if ({busy, ir_valid, inst_addr} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL start_fetch: got busy=%b v=%b addr=%h, want 1 0 0000", busy, ir_valid, inst_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({ir_valid, ir, ir_pc} !== {1'b1, exp_ir[i], 16'(i)}) begin
                n_fail++;
                $display("FAIL seq_capture%0d: got v=%b ir=%h pc=%h, want 1 %h %h",
                         i, ir_valid, ir, ir_pc, exp_ir[i], 16'(i));
            end
        end
        n_checks++;
        if ({halted, busy, inst_addr} !== {1'b1, 1'b0, 16'h0002}) begin
            n_fail++;
            $display("FAIL halt_entry: got h=%b b=%b addr=%h, want 1 0 0002", halted, busy, inst_addr);
        end
        ir_ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({ir_valid, ir, halted, inst_addr} !== {1'b1, 10'h380, 1'b1, 16'h0002}) begin
            n_fail++;
            $display("FAIL halt_hold: got v=%b ir=%h h=%b addr=%h, want 1 380 1 0002",
                     ir_valid, ir, halted, inst_addr);
        end
        ir_ready = 1'b1;
        tick();
        n_checks++;
        if (ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_consume: got v=%b, want 0", ir_valid);
        end
    endtask

    task automatic test_stall();
        ir_ready = 1'b0;
        pulse_start();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({ir_valid, ir, ir_pc, inst_addr} !== {1'b1, 10'h118, 16'h0000, 16'h0001}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b ir=%h ir_pc=%h addr=%h, want 1 118 0000 0001",
                         i, ir_valid, ir, ir_pc, inst_addr);
            end
        end
        ir_ready = 1'b1;
        tick();
        n_checks++;
        if ({ir_valid, ir, ir_pc} !== {1'b1, 10'h05F, 16'h0001}) begin
            n_fail++;
            $display("FAIL stall_resume: got v=%b ir=%h ir_pc=%h, want 1 05f 0001", ir_valid, ir, ir_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if ({fetch_count, stall_count} !== {32'd2, 32'd3}) begin
            n_fail++;
            $display("FAIL perf_stall: got fetch=%0d stall=%0d, want 2 3", fetch_count, stall_count);
        end
`endif
        tick();
    endtask

    task automatic test_redirect();
        pulse_start();
        tick();
        redirect_valid = 1'b1;
        redirect_target = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({ir_valid, busy, inst_addr} !== {1'b0, 1'b1, 16'h0010}) begin
            n_fail++;
            $display("FAIL redirect_bubble: got v=%b b=%b addr=%h, want 0 1 0010", ir_valid, busy, inst_addr);
        end
        tick();
        n_checks++;
        if ({ir_valid, ir, ir_pc} !== {1'b1, rom[16'h0010], 16'h0010}) begin
            n_fail++;
            $display("FAIL redirect_target: got v=%b ir=%h ir_pc=%h, want 1 %h 0010",
                     ir_valid, ir, ir_pc, rom[16'h0010]);
        end
    endtask

    task automatic test_halt_redirect();
        redirect_valid = 1'b1;
        redirect_target = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        ir_ready = 1'b0;
        tick();
        n_checks++;
        if ({halted, ir_valid, ir} !== {1'b1, 1'b1, 10'h380}) begin
            n_fail++;
            $display("FAIL halt_unconsumed: got h=%b v=%b ir=%h, want 1 1 380", halted, ir_valid, ir);
        end
        redirect_valid = 1'b1;
        redirect_target = 16'h0004;
        start = 1'b1;
        tick();
        start = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if ({ir_valid, busy, halted, inst_addr} !== {1'b0, 1'b1, 1'b0, 16'h0004}) begin
            n_fail++;
            $display("FAIL halt_redirect: got v=%b b=%b h=%b addr=%h, want 0 1 0 0004",
                     ir_valid, busy, halted, inst_addr);
        end
        ir_ready = 1'b1;
        tick();
        n_checks++;
        if ({ir_valid, ir_pc} !== {1'b1, 16'h0004}) begin
            n_fail++;
            $display("FAIL halt_redirect_fetch: got v=%b ir_pc=%h, want 1 0004", ir_valid, ir_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (flush_count !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_flush: got %0d, want 3", flush_count);
        end
`endif
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_target = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if ({ir_valid, ir, ir_pc, inst_addr} !== {1'b1, rom[16'hFFFF], 16'hFFFF, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_top: got v=%b ir=%h ir_pc=%h addr=%h, want 1 %h ffff 0000",
                     ir_valid, ir, ir_pc, inst_addr, rom[16'hFFFF]);
        end
        tick();
        n_checks++;
        if ({ir, ir_pc} !== {10'h118, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_zero: got ir=%h ir_pc=%h, want 118 0000", ir, ir_pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        ir_ready = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({ir_valid, inst_addr, busy, halted} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b addr=%h b=%b h=%b, want 0 0000 0 0",
                     ir_valid, inst_addr, busy, halted);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy, ir_valid, inst_addr} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_stays_idle: got b=%b v=%b addr=%h, want 0 0 0000", busy, ir_valid, inst_addr);
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 64; a++) begin
            rom[a] = 10'($urandom);
            if ($urandom_range(0, 7) == 0) rom[a][9:6] = 4'b1110;
            else if (rom[a][9:6] == 4'b1110) rom[a][9:6] = 4'b0000;
        end
        for (int i = 0; i < 600; i++) begin
            start           = ($urandom_range(0, 9) == 0);
            ir_ready        = ($urandom_range(0, 3) != 0);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = 16'($urandom_range(0, 63));
            tick();
            n_checks++;
            if ({inst_addr, ir_valid, halted, busy} !== {m_pc, m_vld, m_halted, m_running}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got addr=%h v=%b h=%b b=%b, want %h %b %b %b",
                         i, inst_addr, ir_valid, halted, busy, m_pc, m_vld, m_halted, m_running);
            end
            if (m_vld) begin
                n_checks++;
                if ({ir, ir_pc} !== {m_ir, m_ir_pc}) begin
                    n_fail++;
                    $display("FAIL rand_ir[%0d]: got ir=%h ir_pc=%h, want %h %h", i, ir, ir_pc, m_ir, m_ir_pc);
                end
            end
`ifdef FETCH_PERF_CNT_EN
            n_checks++;
            if ({fetch_count, stall_count, flush_count} !== {32'(m_fc), 32'(m_sc), 16'(m_flc)}) begin
                n_fail++;
                $display("FAIL rand_perf[%0d]: got %0d %0d %0d, want %0d %0d %0d",
                         i, fetch_count, stall_count, flush_count, m_fc, m_sc, m_flc);
            end
`endif
        end
        start = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] v;
        for (int a = 0; a < 65536; a++) begin
            v = 10'($urandom);
            if (v[9:6] == 4'b1110) v[9:6] = 4'b0000;
            rom[a] = v;
        end
        rom[0] = 10'b0100011000;
        rom[1] = 10'b0001011111;
        rom[2] = 10'b1110000000;

        reset = 1'b1;
        start = 1'b0;
        ir_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_halt_redirect();
        test_wrap();
        test_reset_mid_stall();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
